// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg
//   Shared types and constants for the PS/2 mouse controller.
//   state_e      : controller sequencing states
//   PS2_*        : command / response bytes exchanged with the mouse
//   PKT_SYNC_BIT : bit of packet byte 0 that is always 1 on a valid header
//   DELTA_W      : width of a signed movement delta (sign bit + 8 data bits)
package ps2_mouse_pkg;

    typedef enum logic [2:0] {
        SEND_EN,
        WAIT_TX,
        WAIT_ACK,
        BYTE0,
        BYTE1,
        BYTE2,
        UPDATE
    } state_e;

    localparam logic [7:0] PS2_CMD_STREAM_EN = 8'hF4;
    localparam logic [7:0] PS2_ACK           = 8'hFA;
    localparam int         PKT_SYNC_BIT      = 3;
    localparam int         DELTA_W           = 9;

endpackage

// File: rtl/ps2_mouse_ctrl_axis_accum.sv
// mouse_axis_accum
//   One cursor axis: adds (or subtracts, when INVERT) a signed 9-bit delta
//   to the held position and saturates the result to [0, MAX].
//   clk_i, reset_i : clock, async active-high reset (position -> MAX/2)
//   delta_i        : signed movement delta
//   ovf_i          : overflow flag; when set the delta is dropped
//   load_i         : apply the delta this cycle
//   pos_o          : registered position
module mouse_axis_accum
    import ps2_mouse_pkg::*;
#(
    parameter int   POS_W  = 9,
    parameter int   MAX    = 319,
    parameter bit   INVERT = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic signed [DELTA_W-1:0] delta_i,
    input  logic                      ovf_i,
    input  logic                      load_i,
    output logic [POS_W-1:0]          pos_o
);

    localparam logic signed [POS_W+1:0] MAX_S   = (POS_W+2)'(MAX);
    localparam logic [POS_W-1:0]        MAX_P   = POS_W'(MAX);
    localparam logic [POS_W-1:0]        RST_POS = POS_W'(MAX / 2);

    logic [POS_W-1:0]        pos_q, pos_d;
    logic signed [POS_W+1:0] pos_s, delta_s, sum_s;

    // Two guard bits above POS_W keep the sum from wrapping for any delta.
    always_comb begin
        pos_s   = signed'({2'b00, pos_q});
        delta_s = {{(POS_W+2-DELTA_W){delta_i[DELTA_W-1]}}, delta_i};
        sum_s   = INVERT ? (pos_s - delta_s) : (pos_s + delta_s);
        if (ovf_i) begin
            pos_d = pos_q;
        end else if (sum_s[POS_W+1]) begin
            pos_d = '0;
        end else if (sum_s > MAX_S) begin
            pos_d = MAX_P;
        end else begin
            pos_d = sum_s[POS_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pos_q <= RST_POS;
        end else if (load_i) begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// ps2_mouse_ctrl
//   Brings a PS/2 mouse into stream mode through ps2_rxtx and turns its
//   3-byte movement packets into a clamped cursor position plus buttons.
//   tx_en_o/tx_data_o/tx_done_i : host-to-device command (always 0xF4)
//   rx_data_i/rx_done_i         : bytes received from the mouse
//   x_pos_o/y_pos_o             : cursor, 0..X_MAX / 0..Y_MAX, down is +Y
//   btn_o                       : {middle, right, left}
//   pkt_valid_o                 : one-cycle pulse when position/buttons update
//   ready_o                     : streaming enabled (sticky until reset)
//   Optional build macro PS2_MOUSE_PKT_TIMEOUT_EN: drops a partial packet if
//   the gap between bytes 0/1/2 reaches PKT_TIMEOUT cycles.
//
// state    | meaning
// SEND_EN  | pulse tx_en_o to send the stream-enable command
// WAIT_TX  | command shifting out, wait for tx_done_i
// WAIT_ACK | wait for 0xFA; resend on timeout
// BYTE0    | wait for a header byte with the sync bit set
// BYTE1    | wait for X delta byte
// BYTE2    | wait for Y delta byte
// UPDATE   | apply deltas, publish buttons, pulse pkt_valid_o
module ps2_mouse_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int X_MAX       = 319,
    parameter int Y_MAX       = 239,
    parameter int POS_W       = 9,
    parameter int ACK_TIMEOUT = 2_500_000,
    parameter int PKT_TIMEOUT = 1_000_000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    output logic             tx_en_o,
    output logic [7:0]       tx_data_o,
    input  logic             tx_done_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_done_i,
    output logic [POS_W-1:0] x_pos_o,
    output logic [POS_W-1:0] y_pos_o,
    output logic [2:0]       btn_o,
    output logic             pkt_valid_o,
    output logic             ready_o
);

    // One down-counter serves both the ACK wait and the inter-byte gap;
    // those phases never overlap.
    localparam int TMR_MAX  = (ACK_TIMEOUT > PKT_TIMEOUT) ? ACK_TIMEOUT : PKT_TIMEOUT;
    localparam int TMR_W    = ($clog2(TMR_MAX) < 1) ? 1 : $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);
`ifdef PS2_MOUSE_PKT_TIMEOUT_EN
    localparam logic [TMR_W-1:0] PKT_LOAD = TMR_W'(PKT_TIMEOUT - 1);
`endif

    state_e           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic             tx_en_q, ready_q, pkt_valid_q;
    logic [2:0]       btn_q, btn_pend_q;
    logic             sx_q, sy_q, ovf_x_q, ovf_y_q;
    logic [7:0]       dx_q, dy_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= SEND_EN;
            tmr_q       <= '0;
            tx_en_q     <= 1'b0;
            ready_q     <= 1'b0;
            pkt_valid_q <= 1'b0;
            btn_q       <= '0;
            btn_pend_q  <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            ovf_x_q     <= 1'b0;
            ovf_y_q     <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
        end else begin
            tx_en_q     <= 1'b0;
            pkt_valid_q <= 1'b0;
            case (state_q)
                SEND_EN: begin
                    tx_en_q <= 1'b1;
                    state_q <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done_i) begin
                        tmr_q   <= ACK_LOAD;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // A real ACK wins over a timeout landing on the same cycle.
                    if (rx_done_i && (rx_data_i == PS2_ACK)) begin
                        ready_q <= 1'b1;
                        state_q <= BYTE0;
                    end else if (tmr_q == '0) begin
                        state_q <= SEND_EN;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                BYTE0: begin
                    if (rx_done_i && rx_data_i[PKT_SYNC_BIT]) begin
                        ovf_y_q    <= rx_data_i[7];
                        ovf_x_q    <= rx_data_i[6];
                        sy_q       <= rx_data_i[5];
                        sx_q       <= rx_data_i[4];
                        btn_pend_q <= rx_data_i[2:0];
`ifdef PS2_MOUSE_PKT_TIMEOUT_EN
                        tmr_q      <= PKT_LOAD;
`endif
                        state_q    <= BYTE1;
                    end
                end
                BYTE1: begin
                    if (rx_done_i) begin
                        dx_q    <= rx_data_i;
`ifdef PS2_MOUSE_PKT_TIMEOUT_EN
                        tmr_q   <= PKT_LOAD;
`endif
                        state_q <= BYTE2;
                    end
`ifdef PS2_MOUSE_PKT_TIMEOUT_EN
                    else if (tmr_q == '0) begin
                        state_q <= BYTE0;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
`endif
                end
                BYTE2: begin
                    if (rx_done_i) begin
                        dy_q    <= rx_data_i;
                        state_q <= UPDATE;
                    end
`ifdef PS2_MOUSE_PKT_TIMEOUT_EN
                    else if (tmr_q == '0) begin
                        state_q <= BYTE0;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
`endif
                end
                UPDATE: begin
                    btn_q       <= btn_pend_q;
                    pkt_valid_q <= 1'b1;
                    state_q     <= BYTE0;
                end
                default: state_q <= SEND_EN;
            endcase
        end
    end

    logic                      load;
    logic signed [DELTA_W-1:0] dx, dy;

    // Positions register on the same edge that raises pkt_valid_o.
    assign load = (state_q == UPDATE);
    assign dx   = {sx_q, dx_q};
    assign dy   = {sy_q, dy_q};

    mouse_axis_accum #(
        .POS_W (POS_W),
        .MAX   (X_MAX),
        .INVERT(1'b0)
    ) u_axis_x (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .delta_i(dx),
        .ovf_i  (ovf_x_q),
        .load_i (load),
        .pos_o  (x_pos_o)
    );

    // PS/2 reports Y up-positive; screen Y grows downward.
    mouse_axis_accum #(
        .POS_W (POS_W),
        .MAX   (Y_MAX),
        .INVERT(1'b1)
    ) u_axis_y (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .delta_i(dy),
        .ovf_i  (ovf_y_q),
        .load_i (load),
        .pos_o  (y_pos_o)
    );

    assign tx_en_o     = tx_en_q;
    assign tx_data_o   = PS2_CMD_STREAM_EN;
    assign btn_o       = btn_q;
    assign pkt_valid_o = pkt_valid_q;
    assign ready_o     = ready_q;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
module tb_ps2_mouse_ctrl;

    localparam int X_MAX   = 319;
    localparam int Y_MAX   = 239;
    localparam int POS_W   = 9;
    localparam int ACK_TO  = 100;
    localparam int PKT_TO  = 50;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             tx_en_o;
    logic [7:0]       tx_data_o;
    logic             tx_done_i = 1'b0;
    logic [7:0]       rx_data_i = 8'h00;
    logic             rx_done_i = 1'b0;
    logic [POS_W-1:0] x_pos_o, y_pos_o;
    logic [2:0]       btn_o;
    logic             pkt_valid_o, ready_o;

    ps2_mouse_ctrl #(
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .POS_W(POS_W),
        .ACK_TIMEOUT(ACK_TO), .PKT_TIMEOUT(PKT_TO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .tx_en_o(tx_en_o), .tx_data_o(tx_data_o), .tx_done_i(tx_done_i),
        .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
        .x_pos_o(x_pos_o), .y_pos_o(y_pos_o), .btn_o(btn_o),
        .pkt_valid_o(pkt_valid_o), .ready_o(ready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    int tx_cnt = 0;
    int pkt_cnt = 0;

    always @(negedge clk_i) begin
        if (tx_en_o) tx_cnt++;
        if (pkt_valid_o) pkt_cnt++;
    end

    // Reference model: cursor state from the packet rules, plain integers.
    int x_m, y_m, btn_m;

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model_reset();
        x_m = X_MAX / 2;
        y_m = Y_MAX / 2;
        btn_m = 0;
    endfunction

    function automatic void model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy;
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        if (!b0[6]) x_m = clampi(x_m + dx, X_MAX);
        if (!b0[7]) y_m = clampi(y_m - dy, Y_MAX);
        btn_m = int'(b0[2:0]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i = b;
        rx_done_i = 1'b1;
        @(posedge clk_i); #1;
        rx_done_i = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done_i = 1'b1;
        @(posedge clk_i); #1;
        tx_done_i = 1'b0;
    endtask

    task automatic wait_tx_en(input int max, output int cyc);
        cyc = 0;
        while (!tx_en_o && cyc < max) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("tx_en_seen", int'(tx_en_o), 1);
    endtask

    task automatic send_pkt_chk(input string name, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input int gap,
                                input int ex, input int ey, input int eb);
        send_byte(b0);
        idle(gap);
        send_byte(b1);
        idle(gap);
        send_byte(b2);
        chk({name, "_valid_early"}, int'(pkt_valid_o), 0);
        idle(1);
        chk({name, "_valid"}, int'(pkt_valid_o), 1);
        chk({name, "_x"}, int'(x_pos_o), ex);
        chk({name, "_y"}, int'(y_pos_o), ey);
        chk({name, "_btn"}, int'(btn_o), eb);
        idle(1);
        chk({name, "_valid_1cyc"}, int'(pkt_valid_o), 0);
    endtask

    task automatic model_pkt_chk(input string name, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input int gap);
        model_pkt(b0, b1, b2);
        send_pkt_chk(name, b0, b1, b2, gap, x_m, y_m, btn_m);
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        int ex, ey, eb;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, t0, p0, tot;
        logic [7:0] b0, b1, b2;

        vecs[0] = '{8'h09, 8'h05, 8'h03, 164, 116, 1};
        vecs[1] = '{8'h18, 8'h00, 8'h00,   0, 116, 0};
        vecs[2] = '{8'h08, 8'hFF, 8'h00, 255, 116, 0};
        vecs[3] = '{8'h08, 8'hFF, 8'h00, 319, 116, 0};
        vecs[4] = '{8'h48, 8'h7F, 8'h02, 319, 114, 0};
        vecs[5] = '{8'h08, 8'h00, 8'h7F, 319,   0, 0};
        vecs[6] = '{8'h28, 8'h00, 8'h00, 319, 239, 0};
        vecs[7] = '{8'h8F, 8'h01, 8'h50, 319, 239, 7};
        vecs[8] = '{8'h1A, 8'hF6, 8'h05, 309, 234, 2};

        model_reset();

        // Reset values
        @(posedge clk_i); #1;
        chk("rst_tx_en", int'(tx_en_o), 0);
        chk("rst_ready", int'(ready_o), 0);
        chk("rst_valid", int'(pkt_valid_o), 0);
        chk("rst_btn", int'(btn_o), 0);
        chk("rst_x", int'(x_pos_o), 159);
        chk("rst_y", int'(y_pos_o), 119);
        chk("tx_data", int'(tx_data_o), 'hF4);
        reset_i = 1'b0;

        // Enable sequence, ACK 50 cycles after tx_done
        wait_tx_en(20, cyc);
        chk("tx_data_at_en", int'(tx_data_o), 'hF4);
        idle(1);
        chk("tx_en_1cyc", int'(tx_en_o), 0);
        idle(2);
        send_byte(8'hFA);              // arrives in WAIT_TX: must be ignored
        chk("early_ack_ignored", int'(ready_o), 0);
        idle(3);
        pulse_tx_done();
        idle(49);
        send_byte(8'hFA);
        chk("ready_set", int'(ready_o), 1);
        idle(3);
        chk("tx_en_count", tx_cnt, 1);
        chk("ready_x", int'(x_pos_o), 159);
        chk("ready_y", int'(y_pos_o), 119);

        // Stray tx_done after ready is ignored
        pulse_tx_done();
        idle(3);
        chk("stray_txdone_tx", tx_cnt, 1);
        chk("stray_txdone_ready", int'(ready_o), 1);

        // Directed vectors
        foreach (vecs[i]) begin
            model_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2);
            send_pkt_chk($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2,
                         i % 3, vecs[i].ex, vecs[i].ey, vecs[i].eb);
        end

        // Stray non-sync byte in BYTE0 is discarded
        p0 = pkt_cnt;
        send_byte(8'h00);
        send_byte(8'h37);
        idle(3);
        chk("stray_no_pkt", pkt_cnt, p0);
        model_pkt_chk("resync", 8'h09, 8'h01, 8'h01, 1);

        // Randomized packets against the model
        for (int i = 0; i < 40; i++) begin
            b0 = 8'($urandom) | 8'h08;
            if ($urandom_range(0, 5) != 0) b0[7:6] = 2'b00;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            model_pkt_chk($sformatf("rnd%0d", i), b0, b1, b2, int'($urandom_range(0, 3)));
        end

`ifdef PS2_MOUSE_PKT_TIMEOUT_EN
        // Stall after byte 1 drops the partial packet
        p0 = pkt_cnt;
        send_byte(8'h09);
        send_byte(8'h10);
        idle(PKT_TO + 5);
        send_byte(8'h05);              // no sync bit: stays in BYTE0
        idle(3);
        chk("pkt_timeout_drop", pkt_cnt, p0);
        model_pkt_chk("after_timeout", 8'h0A, 8'h02, 8'hFE, 0);
`else
        // Without the timeout a long stall still completes the packet
        model_pkt_chk("long_stall", 8'h0C, 8'h03, 8'h04, 200);
`endif

        // Reset in BYTE2
        send_byte(8'h09);
        send_byte(8'h20);
        reset_i = 1'b1;
        #1;
        chk("midrst_x", int'(x_pos_o), 159);
        chk("midrst_y", int'(y_pos_o), 119);
        chk("midrst_ready", int'(ready_o), 0);
        chk("midrst_btn", int'(btn_o), 0);
        chk("midrst_valid", int'(pkt_valid_o), 0);
        idle(3);
        model_reset();
        reset_i = 1'b0;
        t0 = tx_cnt;

        // Fresh enable, no ACK -> retry after ACK_TIMEOUT; 0xAB ignored
        wait_tx_en(20, cyc);
        idle(4);
        pulse_tx_done();
        idle(30);
        send_byte(8'hAB);
        chk("ab_ignored", int'(ready_o), 0);
        wait_tx_en(ACK_TO + 20, cyc);
        tot = 32 + cyc;
        chk("retry_window", int'(tot >= ACK_TO && tot <= ACK_TO + 3), 1);
        chk("retry_not_ready", int'(ready_o), 0);
        idle(4);
        chk("retry_tx_count", tx_cnt - t0, 2);
        pulse_tx_done();
        idle(10);
        send_byte(8'hFA);
        chk("retry_ready", int'(ready_o), 1);
        model_pkt_chk("post_retry", 8'h39, 8'hF0, 8'hEC, 1);
        idle(3);
        chk("final_tx_count", tx_cnt - t0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
